// File: rtl/mux_scan.sv
// mux_scan: N-channel time-division multiplexer with a registered, handshaked
// output. The channel comes from `sel` (manual) or from a round-robin scan
// pointer that dwells DWELL accepted samples on each enabled channel.
module mux_scan #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CH    = 4,
  parameter int unsigned DWELL = 4,
  parameter int unsigned SELW  = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [CH-1:0]         mask,
  input  logic [CH*WIDTH-1:0]   in,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;
  logic [DCW-1:0]   r_dcnt;
  logic             r_mode_q;

  logic [WIDTH-1:0] w_ch_data [CH];
  logic [SELW-1:0]  w_scan_tgt;
  logic [SELW-1:0]  w_target;
  logic             w_target_ok;
  logic             w_free;
  logic             w_load;
  logic [DCW-1:0]   w_dcnt_eff;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [DCW-1:0]   w_dcnt_nxt;

  // Unflatten the input bus into one word per channel
  for (genvar g = 0; g < CH; g++) begin : g_unpack
    assign w_ch_data[g] = in[g*WIDTH +: WIDTH];
  end

  // First enabled channel searching cyclically from the scan pointer
  always_comb begin
    int unsigned v_idx;
    logic        v_found;
    w_scan_tgt = r_ptr;
    v_found    = 1'b0;
    v_idx      = 0;
    for (int unsigned k = 0; k < CH; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= CH) begin
        v_idx = v_idx - CH;
      end
      if (!v_found && mask[SELW'(v_idx)]) begin
        w_scan_tgt = SELW'(v_idx);
        v_found    = 1'b1;
      end
    end
  end

  // Target selection, load decision and next scan pointer / dwell count
  always_comb begin
    w_free      = !r_valid || out_ready;
    w_target    = sel;
    w_target_ok = 1'b0;
    if (mode) begin
      w_target    = w_scan_tgt;
      w_target_ok = |mask;
    end else begin
      w_target_ok = (32'(sel) < CH) && mask[sel];
    end
    w_load = en && w_free && w_target_ok;

    // Fresh dwell on entering scan mode or when the pointer's channel was skipped
    w_dcnt_eff = ((mode && !r_mode_q) || (w_target != r_ptr)) ? '0 : r_dcnt;
    if (w_dcnt_eff == DCW'(DWELL - 1)) begin
      w_ptr_nxt  = (w_target == SELW'(CH - 1)) ? '0 : w_target + SELW'(1);
      w_dcnt_nxt = '0;
    end else begin
      w_ptr_nxt  = w_target;
      w_dcnt_nxt = w_dcnt_eff + DCW'(1);
    end
  end

  // Output register, scan state and mode history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_ptr    <= '0;
      r_dcnt   <= '0;
      r_mode_q <= 1'b0;
    end else begin
      r_mode_q <= mode;
      if (w_load) begin
        r_data  <= w_ch_data[w_target];
        r_ch    <= w_target;
        r_valid <= 1'b1;
        if (mode) begin
          r_ptr  <= w_ptr_nxt;
          r_dcnt <= w_dcnt_nxt;
        end
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed scenarios plus randomized traffic against a
// behavioural model of the multiplexer's selection and handshake rules.
module tb_mux_scan;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int DWELL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mode;
  logic [1:0]       sel;
  logic [CH-1:0]    mask;
  logic [31:0]      in_bus;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_ch;
  logic             out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_ptr;
  int       m_dcnt;
  bit       m_modeq;

  mux_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .in(in_bus), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_dcnt = 0; m_modeq = 0;
  endtask

  // One clock edge: advance the model from the inputs in force, then compare
  task automatic step();
    bit free, ok, ld;
    int tgt, d, idx;
    @(posedge clk);
    free = !m_valid || out_ready;
    if (!mode) begin
      tgt = int'(sel);
      ok  = (tgt < CH) && (((mask >> tgt) & 1) != 0);
    end else begin
      ok  = (mask != 0);
      tgt = m_ptr;
      for (int k = CH - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % CH;
        if (((mask >> idx) & 1) != 0) tgt = idx;
      end
    end
    ld = en && free && ok;
    if (ld) begin
      m_data  = 8'(in_bus >> (tgt * WIDTH));
      m_ch    = tgt;
      m_valid = 1;
      if (mode) begin
        d = (tgt != m_ptr || !m_modeq) ? 0 : m_dcnt;
        if (d == DWELL - 1) begin
          m_ptr  = (tgt + 1) % CH;
          m_dcnt = 0;
        end else begin
          m_ptr  = tgt;
          m_dcnt = d + 1;
        end
      end
    end else if (free) begin
      m_valid = 0;
    end
    m_modeq = mode;
    #1;
    check("data",  32'(out_data),  32'(m_data));
    check("ch",    32'(out_ch),    32'(m_ch));
    check("valid", 32'(out_valid), 32'(m_valid));
    check("ptr",   32'(dut.r_ptr), 32'(m_ptr));
  endtask

  task automatic step_ch(input string tag, input int exp_ch);
    step();
    check(tag, 32'(out_ch), 32'(exp_ch));
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_scan [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_skip [6]  = '{1, 1, 3, 3, 1, 1};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; mask = 4'hF;
    in_bus = 32'h33221100; out_ready = 1'b1;
    model_reset();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Manual selection
    en = 1'b1;
    sel = 2'd2; step(); check("man_d0", 32'(out_data), 32'h22); check("man_c0", 32'(out_ch), 32'd2);
    sel = 2'd0; step(); check("man_d1", 32'(out_data), 32'h00); check("man_c1", 32'(out_ch), 32'd0);
    sel = 2'd3; step(); check("man_d2", 32'(out_data), 32'h33); check("man_c2", 32'(out_ch), 32'd3);
    sel = 2'd2; mask = 4'hB; step(); check("man_masked", 32'(out_valid), 32'd0);

    // Scan dwell and wrap
    mode = 1'b1; mask = 4'hF;
    foreach (exp_scan[i]) step_ch("scan_ch", exp_scan[i]);

    // Asynchronous reset while a sample is held
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data",  32'(out_data),  32'd0);
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Masked channels skipped, then all masked, then restored
    en = 1'b1; mode = 1'b1; mask = 4'b1010;
    foreach (exp_skip[i]) step_ch("skip_ch", exp_skip[i]);
    mask = 4'b0000;
    step(); check("allmask_valid", 32'(out_valid), 32'd0); check("allmask_ptr", 32'(dut.r_ptr), 32'd2);
    step(); check("allmask_ptr2", 32'(dut.r_ptr), 32'd2);
    mask = 4'b1010;
    step_ch("resume_ch", 3);

    // Backpressure holds the sample and the scan state
    hard_reset();
    mode = 1'b1; mask = 4'hF; out_ready = 1'b1;
    step_ch("bp_first", 0);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      check("bp_hold_d", 32'(out_data), 32'h00);
      check("bp_hold_v", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step_ch("bp_rel0", 0);
    step_ch("bp_rel1", 1);
    step_ch("bp_rel2", 1);
    step_ch("bp_rel3", 2);

    // Scan -> manual -> scan restarts the dwell
    hard_reset();
    mode = 1'b1; mask = 4'hF;
    step_ch("ms_s0", 0); step_ch("ms_s1", 0); step_ch("ms_s2", 1);
    mode = 1'b0; sel = 2'd3;
    step_ch("ms_m0", 3); step_ch("ms_m1", 3);
    mode = 1'b1;
    step_ch("ms_r0", 1); step_ch("ms_r1", 1); step_ch("ms_r2", 2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 2'($urandom);
      mask      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      in_bus    = $urandom;
      step();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #2;
        model_reset();
        check("rnd_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit time-division multiplexer with a registered, handshaked output. It picks one channel per sample, either directly from `sel` (manual mode) or by a round-robin scan pointer that stays on each enabled channel for `DWELL` accepted samples (scan mode). It sits between a bank of parallel sources and a single serial consumer, and replaces the fixed 4:1 combinational selector wherever channels must be multiplexed over time.

## Interface
- `WIDTH`, 1, bit width of each channel.
- `CH`, 4, channel count. Must be ≥ 2; need not be a power of two.
- `DWELL`, 4, accepted samples per channel before the scan pointer advances. Must be ≥ 1.
- `SELW`, derived as `$clog2(CH)`, width of channel indices.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sampling enable. When 0, nothing is captured, pointer and dwell count freeze, and the output register keeps its handshake.
- `mode`  in  1  0 = manual (`sel`), 1 = scan (pointer).
- `sel`  in  SELW  manual channel index.
- `mask`  in  CH  per-channel enable, 1 = eligible. Applies in both modes.
- `in`  in  CH*WIDTH  flattened inputs; channel k is `in[k*WIDTH +: WIDTH]`.
- `out_data`  out  WIDTH  captured sample.
- `out_ch`  out  SELW  index of the channel that produced `out_data`.
- `out_valid`  out  1  sample held in the output register.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.

## Operation
- **Reset values:** `out_data`=0, `out_ch`=0, `out_valid`=0, `ptr`=0, `dcnt`=0, `mode_q`=0.
- **Slot free:** `free = !out_valid || out_ready`.
- **Load:** `load = en && free && target_ok`. On load, capture `in[target]` into `out_data`, set `out_ch=target`, set `out_valid=1`.
- **No load:** if `free` is true but `load` is false, `out_valid` goes to 0 (the sample was consumed). If `free` is false, all outputs hold.
- **Manual mode, target:** `target = sel`. `target_ok = (sel < CH) && mask[sel]`. An out-of-range or masked `sel` captures nothing. `ptr` and `dcnt` are not modified.
- **Scan mode, target:** `target` is the first channel with `mask` set, searching cyclically `ptr, ptr+1, …, CH-1, 0, …`. `target_ok = |mask`.
  - On load with `dcnt == DWELL-1`: `ptr <= (target+1) mod CH`, `dcnt <= 0`.
  - On any other load: `ptr <= target`, `dcnt <= dcnt+1`.
  - If `target != ptr` (current channel masked), `dcnt` is first treated as 0, so the new channel gets a full dwell.
- **Mode change:** `mode_q` registers `mode`. In the cycle where `mode` differs from `mode_q` and `mode`=1 (manual→scan), `dcnt` is treated as 0. `ptr` is retained. Scan→manual leaves `ptr`/`dcnt` unchanged.
- **Wrap-around:** the pointer goes from CH-1 to 0. When CH is not a power of two, indices ≥ CH are never produced.
- **All masked in scan mode:** no loads. `out_valid` drains to 0. The state stays unchanged until any `mask` bit is set.
- **Reset mid-operation:** a pending unaccepted sample is discarded. `out_valid` drops asynchronously.

## Timing
- Latency: `in` to `out_data` is 1 cycle (captured on the edge where `load`=1).
- Throughput: one sample per cycle while `out_ready`=1 and `target_ok`.
- Backpressure: while `out_valid && !out_ready`, `out_data`/`out_ch`/`out_valid` are stable, and `ptr`/`dcnt` do not change.
- Simultaneous accept + load: in the same edge, the old sample is consumed and the new one is captured. `out_valid` stays 1 with no bubble.
- `en`, `mode`, `sel`, `mask`, `in` are sampled only on rising edges. No combinational path from any input to any output.

## Test plan
All scenarios use CH=4, WIDTH=8, DWELL=2, with `in` = {ch3=0x33, ch2=0x22, ch1=0x11, ch0=0x00}.

- **Reset:** assert `rst` mid-stream with `out_valid`=1 → outputs 0 immediately. After release with `en`=0, `out_valid` stays 0.
- **Manual:** `mode`=0, `mask`=4'hF, `out_ready`=1, `sel` sequence 2,0,3 → `out_data` 0x22,0x00,0x33 and `out_ch` 2,0,3, each one cycle later. `sel`=2 with `mask`=4'hB → no capture and `out_valid`=0.
- **Scan dwell/wrap:** `mode`=1, `mask`=4'hF, `out_ready`=1 for 10 cycles → `out_ch` sequence 0,0,1,1,2,2,3,3,0,0.
- **Masked skip:** scan with `mask`=4'b1010 → `out_ch` 1,1,3,3,1,1. Set `mask`=0 → `out_valid` drops after one accept and `ptr` is unchanged. Restore `mask` → resumes at the first unmasked channel from `ptr`.
- **Backpressure:** scan, `out_ready` low for 3 cycles after the first load → `out_data`=0x00, `out_ch`=0 held stable. Sequence after release is 0,1,1,2 (the held sample counts once).
- **Mode switch:** scan to `out_ch`=1 with `dcnt`=1, switch to manual with `sel`=3 for 2 samples, then back to scan → manual yields 3,3, then scan yields 1,1,2 (dwell restarted).
